dsp48a1_seq: RTL and testbench
==============================

Name: dsp48a1_seq

Overview:
Hardware initiator for the DSP48A1 slice. It accepts operand packets over a valid/ready stream and drives the slice's data, OPMODE, CE and RST pins. It tracks the in-flight pipeline with a valid shift register and captures P/M/CARRYOUT into a result FIFO with valid/ready backpressure. It sits between a host/packet engine and one DSP48A1 instance, and replaces file-driven stimulus for on-chip use.

Parameters:
PIPE_LAT, 4, edges from loading dsp_* drive registers to P/M/CARRYOUT valid on the slice outputs (matches A1REG=B1REG=MREG=PREG=OPMODEREG=CARRYINREG=1)
RES_DEPTH, 4, result FIFO depth, power of two, >=2
RST_CYCLES, 2, cycles dsp_RST is held high in INIT

Ports:
CLK  in  1  single clock
RST  in  1  synchronous active-high reset
in_valid  in  1  operand packet valid
in_ready  out  1  packet accepted when in_valid&in_ready at CLK rise
in_A, in_B, in_D  in  18 each  operands
in_C  in  48  operand
in_OPMODE  in  8  DSP48A1 OPMODE
in_CARRYIN  in  1  carry in
flush_req  in  1  drain pipeline, then reset slice
flush_done  out  1  one-cycle pulse when flush completes
dsp_A, dsp_B, dsp_D  out  18 each  registered drive to slice
dsp_C  out  48  registered drive
dsp_OPMODE  out  8  registered drive
dsp_CARRYIN  out  1  registered drive
dsp_CE  out  1  fanned to all slice CE pins; constant 1
dsp_RST  out  1  fanned to all slice RST pins
dsp_P  in  48  slice P
dsp_M  in  36  slice M
dsp_CARRYOUT  in  1  slice CARRYOUT
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_P  out  48  captured P
out_M  out  36  captured M
out_CARRYOUT  out  1  captured CARRYOUT

Behaviour:
- RST: state=INIT, inflight=0, valid_sr=0, FIFO empty, out_valid=0, in_ready=0, flush_done=0, dsp_RST=1, dsp_* drive = bubble, dsp_CE=1.
- Bubble drive: A=B=C=D=0, CARRYIN=0, OPMODE=BUBBLE_OPMODE=8'h08 (X=0, Z=P, add), so P holds and accumulation survives idle cycles.
- States:
  - INIT: dsp_RST=1 for RST_CYCLES cycles, then go to RUN. flush_done pulses on this exit only when INIT was entered from FLUSH.
  - RUN: in_ready = (inflight + fifo_count) < RES_DEPTH, using registered counts only; a simultaneous pop earns no same-cycle credit. flush_req=1 goes to FLUSH.
  - FLUSH: in_ready=0. Wait for inflight==0, then go to INIT. FIFO contents are preserved.
- flush_req is ignored in INIT and FLUSH. If in_valid and flush_req are both high in RUN with in_ready=1, the packet is accepted and FLUSH starts on the next cycle.
- Accept at edge k: dsp_* registers load the packet and valid_sr[0] is set. With no accept, dsp_* load the bubble.
- valid_sr shifts every cycle. At edge k+PIPE_LAT, {dsp_CARRYOUT, dsp_M, dsp_P} is written to the FIFO. out_valid is first high in the cycle after that edge, so accept-to-out_valid is PIPE_LAT cycles.
- inflight = popcount of valid_sr: +1 on accept, -1 on capture, both on the same edge gives no change.
- The credit scheme guarantees no FIFO overflow; an assertion fires if a write hits a full FIFO.
- Results leave the FIFO strictly in order. Outputs are held stable while out_valid=1 and out_ready=0.
- RST mid-operation discards all in-flight operands and FIFO contents and re-enters INIT.
- Width rules: no arithmetic is done in this block beyond the counters. inflight and fifo_count are $clog2(RES_DEPTH)+1 bits wide.

Decomposition:
- Package dsp48a1_seq_pkg holds:
  - width constants W_AB=18, W_C=48, W_M=36, W_OP=8;
  - BUBBLE_OPMODE=8'h08;
  - state enum {INIT, RUN, FLUSH};
  - packed struct result_t {carryout, m, p} (85 bits).
- One sub-module, dsp48a1_seq_fifo: synchronous FIFO of result_t with RES_DEPTH entries, push/pop/full/empty/count.

Test Plan:
- Reset: hold RST 1 cycle -> dsp_RST high exactly RST_CYCLES=2 cycles after RST falls, in_ready=0 meanwhile, then in_ready=1 and out_valid=0.
- Multiply: A=3, B=5, OPMODE=8'h01 -> out_valid 4 cycles after accept with P=15, M=15, CARRYOUT=0.
- Accumulate across gap: OPMODE=8'h09 with (2,3), 3 idle cycles, then (4,5) -> results P=6 then P=26 (bubbles hold P).
- Post-subtract: C=100, A=3, B=4, OPMODE=8'h8D -> P=88, M=12.
- Backpressure: out_ready=0, offer 6 back-to-back packets (1..6)x1 with OPMODE=8'h01 -> exactly 4 accepted and in_ready low. Raise out_ready -> P=1,2,3,4 then 5,6 in order, no loss or duplicate.
- Flush and mid-op reset:
  - Issue 2 packets, then flush_req -> both results delivered, then dsp_RST pulse, then flush_done pulse, then next accumulate starts from P=0.
  - Repeat with RST asserted 2 cycles after issue -> no results emerge, FIFO empty.

Source files
------------

// File: rtl/dsp48a1_seq_pkg.sv
// Shared widths, bubble opcode, sequencer states and the captured result record.
package dsp48a1_seq_pkg;

    localparam int unsigned W_AB = 18;
    localparam int unsigned W_C  = 48;
    localparam int unsigned W_M  = 36;
    localparam int unsigned W_OP = 8;

    // X=0, Z=P, add: P holds its value, so an accumulation survives idle cycles.
    localparam logic [W_OP-1:0] BUBBLE_OPMODE = 8'h08;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } state_t;

    typedef struct packed {
        logic            carryout;
        logic [W_M-1:0]  m;
        logic [W_C-1:0]  p;
    } result_t;

endpackage

// File: rtl/dsp48a1_seq_fifo.sv
// Synchronous result FIFO: power-of-two depth, registered occupancy count.
module dsp48a1_seq_fifo
    import dsp48a1_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  result_t                wdata,
    input  logic                   pop,
    output result_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        full    = (count_q == DEPTH[AW:0]);
        empty   = (count_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        rdata   = mem[rd_ptr_q];
        count   = count_q;
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit scheme must never let a capture land in a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dsp48a1_seq.sv
// DSP48A1 initiator: streams operand packets into the slice, tracks the
// pipeline with a valid shift register and buffers P/M/CARRYOUT for the host.
module dsp48a1_seq
    import dsp48a1_seq_pkg::*;
#(
    parameter int unsigned PIPE_LAT   = 4,
    parameter int unsigned RES_DEPTH  = 4,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_AB-1:0] in_A,
    input  logic [W_AB-1:0] in_B,
    input  logic [W_AB-1:0] in_D,
    input  logic [W_C-1:0]  in_C,
    input  logic [W_OP-1:0] in_OPMODE,
    input  logic            in_CARRYIN,
    input  logic            flush_req,
    output logic            flush_done,
    output logic [W_AB-1:0] dsp_A,
    output logic [W_AB-1:0] dsp_B,
    output logic [W_AB-1:0] dsp_D,
    output logic [W_C-1:0]  dsp_C,
    output logic [W_OP-1:0] dsp_OPMODE,
    output logic            dsp_CARRYIN,
    output logic            dsp_CE,
    output logic            dsp_RST,
    input  logic [W_C-1:0]  dsp_P,
    input  logic [W_M-1:0]  dsp_M,
    input  logic            dsp_CARRYOUT,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W_C-1:0]  out_P,
    output logic [W_M-1:0]  out_M,
    output logic            out_CARRYOUT
);

    localparam int unsigned CW          = $clog2(RES_DEPTH) + 1;
    localparam int unsigned RCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned INIT_LAST_I = RST_CYCLES - 1;
    localparam logic [RCW-1:0] INIT_LAST  = INIT_LAST_I[RCW-1:0];
    localparam logic [CW:0]    CREDIT_MAX = RES_DEPTH[CW:0];

    state_t               state_q, state_d;
    logic [RCW-1:0]       init_cnt_q, init_cnt_d;
    logic                 from_flush_q, from_flush_d;
    logic                 flush_done_q, flush_done_d;
    logic [PIPE_LAT-1:0]  valid_sr_q, valid_sr_d;
    logic [CW-1:0]        inflight_q, inflight_d;

    logic                 accept;
    logic                 capture;
    logic [CW:0]          credit_used;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    result_t              fifo_wdata;
    result_t              fifo_rdata;

    // Handshakes and credit: registered counts only, so a same-cycle pop earns nothing.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
        in_ready    = (state_q == RUN) && (credit_used < CREDIT_MAX);
        accept      = in_valid & in_ready;
        capture     = valid_sr_q[PIPE_LAT-1];
        fifo_pop    = out_valid & out_ready;
        fifo_wdata  = '{carryout: dsp_CARRYOUT, m: dsp_M, p: dsp_P};
    end

    // Sequencer next state plus pipeline-tracking counters.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        from_flush_d = from_flush_q;
        flush_done_d = 1'b0;
        valid_sr_d   = {valid_sr_q[PIPE_LAT-2:0], accept};
        inflight_d   = inflight_q;

        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d      = RUN;
                    init_cnt_d   = '0;
                    flush_done_d = from_flush_q;
                    from_flush_d = 1'b0;
                end else begin
                    init_cnt_d = init_cnt_q + RCW'(1);
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (inflight_q == '0) begin
                    state_d      = INIT;
                    init_cnt_d   = '0;
                    from_flush_d = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        case ({accept, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            from_flush_q <= 1'b0;
            flush_done_q <= 1'b0;
            valid_sr_q   <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            from_flush_q <= from_flush_d;
            flush_done_q <= flush_done_d;
            valid_sr_q   <= valid_sr_d;
            inflight_q   <= inflight_d;
        end
    end

    // Slice drive registers: the accepted packet, otherwise a P-holding bubble.
    always_ff @(posedge CLK) begin
        if (RST || !accept) begin
            dsp_A       <= '0;
            dsp_B       <= '0;
            dsp_D       <= '0;
            dsp_C       <= '0;
            dsp_OPMODE  <= BUBBLE_OPMODE;
            dsp_CARRYIN <= 1'b0;
        end else begin
            dsp_A       <= in_A;
            dsp_B       <= in_B;
            dsp_D       <= in_D;
            dsp_C       <= in_C;
            dsp_OPMODE  <= in_OPMODE;
            dsp_CARRYIN <= in_CARRYIN;
        end
    end

    // Slice control pins and result outputs straight from registers / FIFO head.
    always_comb begin
        dsp_CE       = 1'b1;
        dsp_RST      = (state_q == INIT);
        flush_done   = flush_done_q;
        out_valid    = ~fifo_empty;
        out_P        = fifo_rdata.p;
        out_M        = fifo_rdata.m;
        out_CARRYOUT = fifo_rdata.carryout;
    end

    dsp48a1_seq_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (capture),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dsp48a1_seq.sv
// Bench for dsp48a1_seq: behavioural DSP48A1 slice, arithmetic scoreboard,
// directed scenarios followed by randomized traffic.
module tb_dsp48a1_seq;
    import dsp48a1_seq_pkg::*;

    typedef struct packed {
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [7:0]  op;
        logic        cin;
    } pkt_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_A = '0, in_B = '0, in_D = '0;
    logic [47:0] in_C = '0;
    logic [7:0]  in_OPMODE = 8'h00;
    logic        in_CARRYIN = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [17:0] dsp_A, dsp_B, dsp_D;
    logic [47:0] dsp_C;
    logic [7:0]  dsp_OPMODE;
    logic        dsp_CARRYIN, dsp_CE, dsp_RST;
    logic [47:0] dsp_P;
    logic [35:0] dsp_M;
    logic        dsp_CARRYOUT;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_P;
    logic [35:0] out_M;
    logic        out_CARRYOUT;

    int          n_total = 0;
    int          n_bad = 0;
    result_t     exp_q[$];
    logic [47:0] got_p[$];
    logic [35:0] got_m[$];
    logic        got_co[$];
    logic [47:0] acc_p = '0;
    logic        held_valid = 1'b0;
    logic [95:0] held_r = '0;

    always #5 CLK = ~CLK;

    dsp48a1_seq #(
        .PIPE_LAT   (4),
        .RES_DEPTH  (4),
        .RST_CYCLES (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_D         (in_D),
        .in_C         (in_C),
        .in_OPMODE    (in_OPMODE),
        .in_CARRYIN   (in_CARRYIN),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .dsp_A        (dsp_A),
        .dsp_B        (dsp_B),
        .dsp_D        (dsp_D),
        .dsp_C        (dsp_C),
        .dsp_OPMODE   (dsp_OPMODE),
        .dsp_CARRYIN  (dsp_CARRYIN),
        .dsp_CE       (dsp_CE),
        .dsp_RST      (dsp_RST),
        .dsp_P        (dsp_P),
        .dsp_M        (dsp_M),
        .dsp_CARRYOUT (dsp_CARRYOUT),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_P        (out_P),
        .out_M        (out_M),
        .out_CARRYOUT (out_CARRYOUT)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // One DSP48A1 operation: optional pre-adder, signed 18x18 multiply, X/Z muxes, post-adder.
    function automatic result_t dsp_eval(input pkt_t k, input logic [47:0] p_prev);
        logic [17:0]        b_eff;
        logic signed [35:0] prod;
        logic [47:0]        x, z;
        logic [48:0]        sum;
        result_t            r;
        b_eff = k.op[4] ? (k.op[6] ? k.d - k.b : k.d + k.b) : k.b;
        prod  = $signed(b_eff) * $signed(k.a);
        case (k.op[1:0])
            2'd0:    x = '0;
            2'd1:    x = {{12{prod[35]}}, prod};
            2'd2:    x = p_prev;
            default: x = {k.d[11:0], k.a, k.b};
        endcase
        case (k.op[3:2])
            2'd2:    z = p_prev;
            2'd3:    z = k.c;
            default: z = '0;
        endcase
        if (k.op[7]) sum = {1'b0, z} - ({1'b0, x} + {48'd0, k.cin});
        else         sum = {1'b0, z} + {1'b0, x} + {48'd0, k.cin};
        r.p        = sum[47:0];
        r.m        = prod;
        r.carryout = sum[48];
        return r;
    endfunction

    function automatic pkt_t mk_pkt(input logic [17:0] a, input logic [17:0] b,
                                    input logic [47:0] c, input logic [17:0] d,
                                    input logic [7:0] op, input logic cin);
        pkt_t k;
        k.a = a; k.b = b; k.c = c; k.d = d; k.op = op; k.cin = cin;
        return k;
    endfunction

    // Slice model: input regs, M stage, then P stage; M and CARRYOUT presented aligned with P.
    pkt_t    s1, s2;
    result_t sres;
    always @(posedge CLK) begin
        if (dsp_RST) begin
            s1   <= '0;
            s2   <= '0;
            sres <= '0;
        end else begin
            s1   <= mk_pkt(dsp_A, dsp_B, dsp_C, dsp_D, dsp_OPMODE, dsp_CARRYIN);
            s2   <= s1;
            sres <= dsp_eval(s2, sres.p);
        end
    end
    assign dsp_P        = sres.p;
    assign dsp_M        = sres.m;
    assign dsp_CARRYOUT = sres.carryout;

    // Scoreboard: expected results computed in accept order against a running P.
    always @(negedge CLK) begin
        result_t r;
        if (RST) begin
            exp_q.delete();
            acc_p      = '0;
            held_valid = 1'b0;
        end else begin
            if (dsp_RST) acc_p = '0;
            if (held_valid) check_eq("hold_stable", {11'd0, out_CARRYOUT, out_M, out_P}, held_r);
            if (out_valid && out_ready) begin
                check_eq("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check_eq("out_P", out_P, r.p);
                    check_eq("out_M", out_M, r.m);
                    check_eq("out_CARRYOUT", out_CARRYOUT, r.carryout);
                end
                got_p.push_back(out_P);
                got_m.push_back(out_M);
                got_co.push_back(out_CARRYOUT);
            end
            if (in_valid && in_ready) begin
                r = dsp_eval(mk_pkt(in_A, in_B, in_C, in_D, in_OPMODE, in_CARRYIN), acc_p);
                acc_p = r.p;
                exp_q.push_back(r);
            end
            held_valid = out_valid && !out_ready;
            held_r     = {11'd0, out_CARRYOUT, out_M, out_P};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                        input logic [17:0] d, input logic [7:0] op, input logic cin);
        int n = 0;
        in_A = a; in_B = b; in_C = c; in_D = d; in_OPMODE = op; in_CARRYIN = cin;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq("send_timeout", n < 100, 1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq(tag, n < 400, 1);
    endtask

    function automatic logic [47:0] last_p(input int back);
        return got_p[got_p.size() - 1 - back];
    endfunction

    initial begin
        int          rst_hi, lat, idx, acc_cnt, base, rst_at, done_at, done_cnt;
        logic [7:0]  ops [8];
        ops = '{8'h01, 8'h09, 8'h0D, 8'h8D, 8'h89, 8'h51, 8'h0B, 8'h0E};

        // Reset state and INIT duration.
        @(posedge CLK);
        #1;
        check_eq("rst_dsp_RST", dsp_RST, 1);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_flush_done", flush_done, 0);
        check_eq("rst_opmode", dsp_OPMODE, 8'h08);
        check_eq("rst_dsp_A", dsp_A, 0);
        check_eq("rst_dsp_CE", dsp_CE, 1);
        RST = 1'b0;
        rst_hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (dsp_RST) begin
                rst_hi++;
                check_eq("init_in_ready", in_ready, 0);
            end
            @(posedge CLK);
            #1;
        end
        check_eq("init_cycles", rst_hi, 2);
        check_eq("run_in_ready", in_ready, 1);
        check_eq("run_out_valid", out_valid, 0);

        // Accumulate across idle gap from P=0.
        out_ready = 1'b1;
        send(18'd2, 18'd3, 48'd0, 18'd0, 8'h09, 1'b0);
        idle(3);
        send(18'd4, 18'd5, 48'd0, 18'd0, 8'h09, 1'b0);
        drain("acc_drain");
        check_eq("acc_first_P", last_p(1), 48'd6);
        check_eq("acc_second_P", last_p(0), 48'd26);

        // Multiply with latency measurement.
        send(18'd3, 18'd5, 48'd0, 18'd0, 8'h01, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_eq("mul_latency", lat, 4);
        drain("mul_drain");
        check_eq("mul_P", last_p(0), 48'd15);
        check_eq("mul_M", got_m[got_m.size() - 1], 36'd15);
        check_eq("mul_CO", got_co[got_co.size() - 1], 0);

        // Post-subtract C - M.
        send(18'd3, 18'd4, 48'd100, 18'd0, 8'h8D, 1'b0);
        drain("sub_drain");
        check_eq("sub_P", last_p(0), 48'd88);
        check_eq("sub_M", got_m[got_m.size() - 1], 36'd12);

        // Backpressure: credits stop acceptance at RES_DEPTH.
        out_ready = 1'b0;
        idx = 1;
        acc_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_A = 18'(idx); in_B = 18'd1; in_C = '0; in_D = '0; in_OPMODE = 8'h01;
            in_CARRYIN = 1'b0;
            in_valid = 1'b1;
            if (in_ready) begin
                acc_cnt++;
                idx++;
            end
            @(posedge CLK);
            #1;
        end
        check_eq("bp_accepted", acc_cnt, 4);
        check_eq("bp_in_ready_low", in_ready, 0);
        check_eq("bp_head_P", out_P, 48'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && idx <= 6; cyc++) begin
            in_A = 18'(idx);
            in_valid = 1'b1;
            if (in_ready) idx++;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        drain("bp_drain");
        for (int i = 0; i < 6; i++) check_eq("bp_order", last_p(5 - i), 48'(i + 1));

        // Flush: results first, then slice reset, then flush_done, then P starts at 0.
        base = got_p.size();
        send(18'd2, 18'd3, 48'd0, 18'd0, 8'h09, 1'b0);
        send(18'd1, 18'd1, 48'd0, 18'd0, 8'h09, 1'b0);
        flush_req = 1'b1;
        @(posedge CLK);
        #1;
        flush_req = 1'b0;
        rst_at = -1; done_at = -1; done_cnt = 0; rst_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (dsp_RST) begin
                rst_hi++;
                if (rst_at < 0) begin
                    rst_at = i;
                    check_eq("flush_results_first", got_p.size() - base, 2);
                end
            end
            if (flush_done) begin
                done_cnt++;
                done_at = i;
            end
            @(posedge CLK);
            #1;
        end
        check_eq("flush_rst_cycles", rst_hi, 2);
        check_eq("flush_done_pulses", done_cnt, 1);
        check_eq("flush_done_after_rst", (rst_at >= 0) && (done_at > rst_at), 1);
        send(18'd2, 18'd3, 48'd0, 18'd0, 8'h09, 1'b0);
        drain("flush_acc_drain");
        check_eq("flush_acc_P", last_p(0), 48'd6);

        // Mid-operation reset discards everything in flight.
        send(18'd7, 18'd7, 48'd0, 18'd0, 8'h01, 1'b0);
        send(18'd8, 18'd8, 48'd0, 18'd0, 8'h01, 1'b0);
        idle(2);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        base = got_p.size();
        idle(15);
        check_eq("midrst_no_results", got_p.size() - base, 0);
        check_eq("midrst_fifo_empty", out_valid, 0);
        send(18'd2, 18'd3, 48'd0, 18'd0, 8'h09, 1'b0);
        drain("midrst_acc_drain");
        check_eq("midrst_acc_P", last_p(0), 48'd6);

        // Randomized traffic with backpressure and occasional flushes.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid   = ($urandom_range(2) != 0);
            in_A       = 18'($urandom);
            in_B       = 18'($urandom);
            in_D       = 18'($urandom);
            in_C       = {16'($urandom), 32'($urandom)};
            in_OPMODE  = ops[$urandom_range(7)];
            in_CARRYIN = 1'($urandom);
            out_ready  = ($urandom_range(3) != 0);
            flush_req  = ($urandom_range(49) == 0);
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        check_eq("rand_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
